// File: rtl/imm_gen_pkg.sv
// Shared types for the immediate-generation stage: format codes, opcodes, FIFO entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_NONE = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    // Entry fields are sized for the widest legal XLEN; narrower builds use the low bits.
    localparam int XLEN_MAX = 64;

    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        logic [XLEN_MAX-1:0] pc_target;
        fmt_e                format;
        logic                illegal;
    } imm_entry_t;

    localparam imm_entry_t RESET_ENTRY = '{imm: '0, pc_target: '0, format: FMT_NONE, illegal: 1'b0};

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational opcode-to-format decode and immediate assembly, sign-extended to XLEN.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
// Ports: instruction_i (raw 32b), imm_o (XLEN), format_o (fmt_e), illegal_o.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instruction_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_e            format_o,
    output logic            illegal_o
);

    logic [31:0] inst;
    logic [31:0] imm32;
    logic [63:0] imm_sext;
    logic        unused_imm_hi;
    fmt_e        fmt;

    assign inst = instruction_i;

    always_comb begin
        fmt       = FMT_NONE;
        illegal_o = 1'b0;
        unique case (inst[6:0])
            OP_OP:                                    fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_MISC_MEM:    fmt = FMT_I;
            OP_STORE:                                 fmt = FMT_S;
            OP_BRANCH:                                fmt = FMT_B;
            OP_LUI, OP_AUIPC:                         fmt = FMT_U;
            OP_JAL:                                   fmt = FMT_J;
            // funct3[2] separates CSR-immediate forms from register/ECALL forms.
            OP_SYSTEM:                                fmt = inst[14] ? FMT_Z : FMT_I;
            default: begin
                fmt       = FMT_NONE;
                illegal_o = 1'b1;
            end
        endcase
    end

    // All formats fit in 32 bits; bit 31 of imm32 is the sign for the final extension.
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm32 = {inst[31:12], 12'b0};
            FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            FMT_Z:   imm32 = {27'b0, inst[19:15]};
            default: imm32 = '0;
        endcase
    end

    assign imm_sext      = {{32{imm32[31]}}, imm32};
    assign imm_o         = imm_sext[XLEN-1:0];
    assign unused_imm_hi = ^imm_sext;
    assign format_o      = fmt;

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator: decode + PC-relative target, buffered in a DEPTH-entry FIFO.
// Latency: 1 cycle from acceptance to head when the FIFO is empty.
// Backpressure: In_ready_o low when full (from registered count only); Flush_i empties FIFO.
// Ports: Clk_i/Rst_ni/Flush_i; In_valid_i/In_ready_o with Instruction_i, Pc_i;
//        Out_valid_o/Out_ready_i with Immediate_o, Format_o, Pc_target_o, Illegal_o.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            Clk_i,
    input  logic            Rst_ni,
    input  logic            Flush_i,
    input  logic            In_valid_i,
    output logic            In_ready_o,
    input  logic [31:0]     Instruction_i,
    input  logic [XLEN-1:0] Pc_i,
    output logic            Out_valid_o,
    input  logic            Out_ready_i,
    output logic [XLEN-1:0] Immediate_o,
    output logic [2:0]      Format_o,
    output logic [XLEN-1:0] Pc_target_o,
    output logic            Illegal_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instruction_i (Instruction_i),
        .imm_o         (dec_imm),
        .format_o      (dec_fmt),
        .illegal_o     (dec_illegal)
    );

    imm_entry_t      new_entry;
    imm_entry_t      head_entry;
    imm_entry_t      mem_q [DEPTH];
    imm_entry_t      mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            push, pop;
    logic            unused_entry_hi;

    always_comb begin
        new_entry                     = RESET_ENTRY;
        new_entry.imm[XLEN-1:0]       = dec_imm;
        new_entry.pc_target[XLEN-1:0] = Pc_i + dec_imm;
        new_entry.format              = dec_fmt;
        new_entry.illegal             = dec_illegal;
    end

    assign In_ready_o  = (count_q < CW'(DEPTH));
    assign Out_valid_o = (count_q != '0);
    assign push        = In_valid_i & In_ready_o;
    assign pop         = Out_valid_o & Out_ready_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Flush_i) begin
            // Flush beats push and pop; stored data is left in place, only bookkeeping clears.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_ENTRY;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is reset to zero/FMT_NONE, so the head read shows reset values out of reset.
    assign head_entry      = mem_q[rd_ptr_q];
    assign Immediate_o     = head_entry.imm[XLEN-1:0];
    assign Pc_target_o     = head_entry.pc_target[XLEN-1:0];
    assign Format_o        = head_entry.format;
    assign Illegal_o       = head_entry.illegal;
    assign unused_entry_hi = ^{head_entry.imm, head_entry.pc_target};

endmodule
